vigenere_stream_decryptor: RTL and testbench
============================================

Name: vigenere_stream_decryptor

Overview:
- Receiver-side Vigenere engine: accepts a ciphertext character stream over a valid/ready handshake and returns plaintext over a second valid/ready handshake.
- Holds a loaded key of up to KEY_CHARS ASCII letters and steps a key pointer once per decrypted letter, wrapping circularly.
- Pairs with the encryption side of the cipher lab path; it is the far end of the Vigenere link.

Parameters:
- KEY_CHARS, 10, maximum key length in characters. Key bus width is 8*KEY_CHARS.

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- keyInput  input  8*KEY_CHARS  key characters; byte 0 (bits 7:0) is the first key char.
- keyLength  input  4  number of valid key chars; 0 or >KEY_CHARS is clamped to KEY_CHARS.
- load  input  1  level; captures keyInput/keyLength on any clock edge where high.
- cipherChar  input  8  ASCII ciphertext character.
- cipherValid  input  1  cipherChar is valid.
- cipherReady  output  1  block can accept cipherChar this cycle.
- decryptedChar  output  8  ASCII plaintext character, registered.
- decryptedValid  output  1  decryptedChar is valid.
- decryptedReady  input  1  downstream accepts decryptedChar.
- keyIndex  output  4  current key pointer, 0..keyLength-1.
- keyLoaded  output  1  high once a key has been captured since reset.

Behaviour:
- Reset (reset==0 at edge): state=NOKEY, keyLoaded=0, keyIndex=0, decryptedValid=0, decryptedChar=8'h00, key register=0, stored length=KEY_CHARS. Reset overrides load and all handshakes.
- States: NOKEY -> RUN on load. RUN -> RUN on load (reload). There is no other exit except reset.
- cipherReady = (state==RUN) && !load && (!decryptedValid || decryptedReady). It is combinational.
- Accept = cipherValid && cipherReady. Latency is 1 cycle: the result is registered on the accept edge, and decryptedValid is high the next cycle.
- Output hold: while decryptedValid && !decryptedReady, decryptedChar and decryptedValid stay stable and no new input is accepted.
- Output retire: decryptedReady && decryptedValid with no accept in the same cycle clears decryptedValid. A simultaneous retire and accept keeps decryptedValid high with the new char, giving full throughput of 1 char/cycle.
- Shift = keyByte[keyIndex] - 'A' if keyByte is in 'A'..'Z'. Otherwise shift=0.
- Letter input ('A'..'Z'): result = cipherChar - shift; add 26 if the result < 'A'. Use 8-bit arithmetic and no modulo operator. Then keyIndex advances: keyIndex==len-1 wraps to 0, else +1.
- Non-letter input (anything outside 'A'..'Z', lowercase included): result = cipherChar unchanged, and keyIndex does not advance.
- Load in any state:
  - Captures key and clamped length.
  - keyIndex=0, keyLoaded=1.
  - decryptedValid=0; a pending output is dropped.
  - No input is accepted that cycle.
- Load held for multiple cycles: re-captures every cycle; cipherReady stays 0.
- reset low while decryptedValid high: the output is discarded, and the block is back in NOKEY the next cycle.

Test Plan:
- Basic decrypt:
  - Stimulus: reset; load key "LEMON" (bytes 0..4 = 4C 45 4D 4F 4E), keyLength=5; stream "LXFOPV" with decryptedReady=1.
  - Response: outputs "ATTACK" on consecutive cycles, first 1 cycle after the first accept; keyIndex sequence 0,1,2,3,4,0.
- Wrap-around arithmetic:
  - Stimulus: key "Z", length 1; input 'A' then 'Z'.
  - Response: 'B' then 'A'; keyIndex stays 0.
  - Stimulus: key "B"; input 'A'.
  - Response: 'Z'.
- Non-letter passthrough:
  - Stimulus: key "LEMON"; input "L X".
  - Response: 'A', ' ', 'T'; keyIndex is 1 after the space, not 2.
- Backpressure:
  - Stimulus: key "LEMON"; send 'L', then hold decryptedReady=0 for 3 cycles with cipherValid=1 on 'X'.
  - Response: decryptedChar='A' held stable; cipherReady=0 for 3 cycles; 'T' appears the cycle after decryptedReady rises.
- Clamp and reload:
  - Stimulus: keyLength=0 with 10-char key "ABCDEFGHIJ"; 11 'Z' inputs.
  - Response: Z,Y,X,W,V,U,T,S,R,Q,Z (index wraps after 10).
  - Stimulus: mid-stream load of a new key.
  - Response: pending output dropped, keyIndex=0, cipherReady=0 during the load cycle.
- Reset behaviour:
  - Stimulus: before any load, cipherValid=1.
  - Response: cipherReady=0 and keyLoaded=0.
  - Stimulus: reset asserted while decryptedValid=1.
  - Response: decryptedValid=0 and keyIndex=0 next cycle; a new load is required before accept.

Source files
------------

// File: rtl/vigenere_stream_decryptor.sv
// Receiver-side Vigenere engine: ciphertext in, plaintext out, both over
// valid/ready, with a circular key pointer that steps once per decrypted letter.
module vigenere_stream_decryptor #(
    parameter int KEY_CHARS = 10
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [8*KEY_CHARS-1:0] keyInput,
    input  logic [3:0]             keyLength,
    input  logic                   load,
    input  logic [7:0]             cipherChar,
    input  logic                   cipherValid,
    output logic                   cipherReady,
    output logic [7:0]             decryptedChar,
    output logic                   decryptedValid,
    input  logic                   decryptedReady,
    output logic [3:0]             keyIndex,
    output logic                   keyLoaded
);

    localparam logic [3:0] KC = 4'(KEY_CHARS);
    localparam logic [7:0] CH_A = 8'h41;
    localparam logic [7:0] CH_Z = 8'h5A;

    typedef enum logic {
        NOKEY,
        RUN
    } state_t;

    state_t                 state_q, state_d;
    logic [8*KEY_CHARS-1:0] key_q, key_d;
    logic [3:0]             len_q, len_d;
    logic [3:0]             key_index_q, key_index_d;
    logic                   key_loaded_q, key_loaded_d;
    logic [7:0]             out_char_q, out_char_d;
    logic                   out_valid_q, out_valid_d;

    logic [7:0] key_byte;
    logic [7:0] shift;
    logic [7:0] diff;
    logic [7:0] plain;
    logic       is_letter;
    logic       accept;
    logic [3:0] len_in;

    always_comb begin
        key_byte = 8'h00;
        for (int i = 0; i < KEY_CHARS; i++) begin
            if (key_index_q == 4'(i)) key_byte = key_q[i*8 +: 8];
        end
    end

    always_comb begin
        shift = 8'h00;
        if (key_byte >= CH_A && key_byte <= CH_Z) shift = key_byte - CH_A;
        is_letter = (cipherChar >= CH_A) && (cipherChar <= CH_Z);
        // Letter minus shift never underflows 8 bits; one +26 fixes the wrap.
        diff = cipherChar - shift;
        plain = (diff < CH_A) ? diff + 8'd26 : diff;
        if (!is_letter) plain = cipherChar;
    end

    assign cipherReady = (state_q == RUN) && !load &&
                         (!out_valid_q || decryptedReady);
    assign accept = cipherValid && cipherReady;
    assign len_in = (keyLength == 4'd0 || keyLength > KC) ? KC : keyLength;

    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        len_d        = len_q;
        key_index_d  = key_index_q;
        key_loaded_d = key_loaded_q;
        out_char_d   = out_char_q;
        out_valid_d  = out_valid_q;
        if (load) begin
            state_d      = RUN;
            key_d        = keyInput;
            len_d        = len_in;
            key_index_d  = 4'd0;
            key_loaded_d = 1'b1;
            out_valid_d  = 1'b0;
        end else if (accept) begin
            out_char_d  = plain;
            out_valid_d = 1'b1;
            if (is_letter) begin
                if (key_index_q == len_q - 4'd1) key_index_d = 4'd0;
                else key_index_d = key_index_q + 4'd1;
            end
        end else if (decryptedReady) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= NOKEY;
            key_q        <= '0;
            len_q        <= KC;
            key_index_q  <= 4'd0;
            key_loaded_q <= 1'b0;
            out_char_q   <= 8'h00;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            len_q        <= len_d;
            key_index_q  <= key_index_d;
            key_loaded_q <= key_loaded_d;
            out_char_q   <= out_char_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign decryptedChar  = out_char_q;
    assign decryptedValid = out_valid_q;
    assign keyIndex       = key_index_q;
    assign keyLoaded      = key_loaded_q;

endmodule

// File: tb/tb_vigenere_stream_decryptor.sv
// Directed bench for vigenere_stream_decryptor with hand-computed vectors.
module tb_vigenere_stream_decryptor;

    localparam int KW = 80;

    logic          clock;
    logic          reset;
    logic [KW-1:0] keyInput;
    logic [3:0]    keyLength;
    logic          load;
    logic [7:0]    cipherChar;
    logic          cipherValid;
    logic          cipherReady;
    logic [7:0]    decryptedChar;
    logic          decryptedValid;
    logic          decryptedReady;
    logic [3:0]    keyIndex;
    logic          keyLoaded;

    int errors = 0;
    int checks = 0;

    vigenere_stream_decryptor #(.KEY_CHARS(10)) dut (
        .clock(clock),
        .reset(reset),
        .keyInput(keyInput),
        .keyLength(keyLength),
        .load(load),
        .cipherChar(cipherChar),
        .cipherValid(cipherValid),
        .cipherReady(cipherReady),
        .decryptedChar(decryptedChar),
        .decryptedValid(decryptedValid),
        .decryptedReady(decryptedReady),
        .keyIndex(keyIndex),
        .keyLoaded(keyLoaded)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_key(input logic [KW-1:0] k, input logic [3:0] len);
        keyInput    = k;
        keyLength   = len;
        load        = 1'b1;
        cipherValid = 1'b0;
        #1;
        chk("load_ready", 32'(cipherReady), 32'd0);
        cyc();
        load = 1'b0;
        chk("load_idx", 32'(keyIndex), 32'd0);
        chk("load_valid", 32'(decryptedValid), 32'd0);
        chk("load_loaded", 32'(keyLoaded), 32'd1);
    endtask

    task automatic send(input logic [7:0] c, input logic [7:0] exp,
                        input logic [3:0] idx);
        cipherChar     = c;
        cipherValid    = 1'b1;
        decryptedReady = 1'b1;
        #1;
        chk("send_ready", 32'(cipherReady), 32'd1);
        cyc();
        chk("send_valid", 32'(decryptedValid), 32'd1);
        chk("send_char", 32'(decryptedChar), 32'(exp));
        chk("send_idx", 32'(keyIndex), 32'(idx));
    endtask

    initial begin
        string ct;
        string pt;
        reset          = 1'b0;
        keyInput       = '0;
        keyLength      = 4'd0;
        load           = 1'b0;
        cipherChar     = 8'h00;
        cipherValid    = 1'b0;
        decryptedReady = 1'b1;
        cyc();
        cyc();
        reset = 1'b1;
        chk("rst_loaded", 32'(keyLoaded), 32'd0);
        chk("rst_valid", 32'(decryptedValid), 32'd0);
        chk("rst_char", 32'(decryptedChar), 32'd0);
        chk("rst_idx", 32'(keyIndex), 32'd0);
        cipherChar  = "L";
        cipherValid = 1'b1;
        #1;
        chk("nokey_ready", 32'(cipherReady), 32'd0);
        cyc();
        chk("nokey_valid", 32'(decryptedValid), 32'd0);

        // LEMON: LXFOPV -> ATTACK
        load_key(80'h4E4F4D454C, 4'd5);
        ct = "LXFOPV";
        pt = "ATTACK";
        for (int i = 0; i < 6; i++) begin
            send(ct[i], pt[i], 4'((i + 1) % 5));
        end
        cipherValid = 1'b0;
        cyc();
        chk("retire_valid", 32'(decryptedValid), 32'd0);
        chk("retire_idx", 32'(keyIndex), 32'd1);

        load_key(80'h5A, 4'd1);
        send("A", "B", 4'd0);
        send("Z", "A", 4'd0);
        load_key(80'h42, 4'd1);
        send("A", "Z", 4'd0);

        load_key(80'h4E4F4D454C, 4'd5);
        send("L", "A", 4'd1);
        send(" ", " ", 4'd1);
        send("X", "T", 4'd2);

        // Backpressure: 'A' must hold while 'X' waits
        load_key(80'h4E4F4D454C, 4'd5);
        send("L", "A", 4'd1);
        decryptedReady = 1'b0;
        cipherChar     = "X";
        cipherValid    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready", 32'(cipherReady), 32'd0);
            cyc();
            chk("bp_char", 32'(decryptedChar), 32'h41);
            chk("bp_valid", 32'(decryptedValid), 32'd1);
            chk("bp_idx", 32'(keyIndex), 32'd1);
        end
        decryptedReady = 1'b1;
        #1;
        chk("bp_release_ready", 32'(cipherReady), 32'd1);
        cyc();
        chk("bp_release_char", 32'(decryptedChar), 32'h54);
        chk("bp_release_valid", 32'(decryptedValid), 32'd1);
        cipherValid = 1'b0;
        cyc();

        // Clamp: length 0 becomes 10
        load_key(80'h4A494847464544434241, 4'd0);
        for (int i = 0; i < 11; i++) begin
            send("Z", 8'(8'h5A - 8'(i % 10)), 4'((i + 1) % 10));
        end
        load           = 1'b1;
        keyInput       = 80'h4E4F4D454C;
        keyLength      = 4'd5;
        #1;
        chk("reload_ready", 32'(cipherReady), 32'd0);
        cyc();
        chk("reload_valid", 32'(decryptedValid), 32'd0);
        chk("reload_idx", 32'(keyIndex), 32'd0);
        #1;
        chk("reload_hold_ready", 32'(cipherReady), 32'd0);
        cyc();
        load = 1'b0;
        chk("reload_hold_valid", 32'(decryptedValid), 32'd0);
        cipherValid = 1'b0;
        send("L", "A", 4'd1);

        // Reset while output pending
        cipherValid = 1'b0;
        reset       = 1'b0;
        cyc();
        reset = 1'b1;
        chk("rst2_valid", 32'(decryptedValid), 32'd0);
        chk("rst2_idx", 32'(keyIndex), 32'd0);
        chk("rst2_loaded", 32'(keyLoaded), 32'd0);
        chk("rst2_char", 32'(decryptedChar), 32'd0);
        cipherChar  = "L";
        cipherValid = 1'b1;
        #1;
        chk("rst2_ready", 32'(cipherReady), 32'd0);
        cyc();
        chk("rst2_noaccept", 32'(decryptedValid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
